// File: rtl/ddr_define.sv
// ddr_define: command-word field positions, issuer FSM encoding and MC source codes
// shared by the DDR command path.
package ddr_define;
    localparam int CMD_W     = 75;
    localparam int VALID_BIT = 0;
    localparam int RSVD_BIT  = 1;
    localparam int POS1_LSB  = 2;
    localparam int POS1_W    = 8;
    localparam int POS2_LSB  = 10;
    localparam int POS2_W    = 3;
    localparam int SRC_LSB   = 13;
    localparam int SRC_W     = 2;
    localparam int ADDR_LSB  = 15;
    localparam int ADDR_FW   = 30;
    localparam int LEN_LSB   = 45;
    localparam int LEN_W     = 30;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} issuer_state_t;

    localparam logic [SRC_W-1:0] SRC_A = 2'b01;
    localparam logic [SRC_W-1:0] SRC_B = 2'b10;

    function automatic logic src_ok(input logic [SRC_W-1:0] s);
        return s == SRC_A || s == SRC_B;
    endfunction
endpackage

// File: rtl/mc_cmd_unpack.sv
// mc_cmd_unpack: combinational slicing of a command FIFO word into its fields.
module mc_cmd_unpack
    import ddr_define::*;
(
    input  logic [CMD_W-1:0]   fifo_dout,
    output logic               valid,
    output logic               rsvd,
    output logic [POS1_W-1:0]  pos_1st,
    output logic [POS2_W-1:0]  pos_2nd,
    output logic [SRC_W-1:0]   src_type,
    output logic [ADDR_FW-1:0] start_addr,
    output logic [LEN_W-1:0]   len
);
    assign valid      = fifo_dout[VALID_BIT];
    assign rsvd       = fifo_dout[RSVD_BIT];
    assign pos_1st    = fifo_dout[POS1_LSB +: POS1_W];
    assign pos_2nd    = fifo_dout[POS2_LSB +: POS2_W];
    assign src_type   = fifo_dout[SRC_LSB +: SRC_W];
    assign start_addr = fifo_dout[ADDR_LSB +: ADDR_FW];
    assign len        = fifo_dout[LEN_LSB +: LEN_W];
endmodule

// File: rtl/mc_cmd_issuer.sv
// mc_cmd_issuer: pops commands from a FIFO and issues them as a run of read bursts.
// Define MC_CMD_ISSUER_CHK_EN to discard malformed commands with an err_o pulse.
module mc_cmd_issuer
    import ddr_define::*;
#(
    parameter int         ADDR_W     = 30,
    parameter int         BURST_STEP = 8,
    parameter logic [2:0] CMD_RD     = 3'b001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [CMD_W-1:0]  fifo_dout,
    input  logic              fifo_valid,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic [POS1_W-1:0] tag_pos_1st_o,
    output logic [POS2_W-1:0] tag_pos_2nd_o,
    output logic [SRC_W-1:0]  tag_src_type_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    issuer_state_t state, state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic               c_valid, c_rsvd, cmd_ok, load;
    logic [POS1_W-1:0]  c_pos_1st;
    logic [POS2_W-1:0]  c_pos_2nd;
    logic [SRC_W-1:0]   c_src;
    logic [ADDR_FW-1:0] c_addr;
    logic [LEN_W-1:0]   c_len;

    mc_cmd_unpack u_unpack (
        .fifo_dout  (fifo_dout),
        .valid      (c_valid),
        .rsvd       (c_rsvd),
        .pos_1st    (c_pos_1st),
        .pos_2nd    (c_pos_2nd),
        .src_type   (c_src),
        .start_addr (c_addr),
        .len        (c_len)
    );

`ifdef MC_CMD_ISSUER_CHK_EN
    logic unused_rsvd;
    assign unused_rsvd = c_rsvd;
    assign cmd_ok = c_valid && src_ok(c_src);
    always_ff @(posedge clk or posedge rst)
        if (rst) err_o <= 1'b0;
        else     err_o <= load && !cmd_ok;
`else
    logic unused_bits;
    assign unused_bits = ^{c_rsvd, c_valid, c_src == SRC_A};
    assign cmd_ok = 1'b1;
    assign err_o  = 1'b0;
`endif

    assign load = state == FETCH && fifo_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fifo_empty ? IDLE : FETCH;
            FETCH:   if (fifo_valid) state_nxt = !cmd_ok ? IDLE : (c_len == '0 ? DONE : ISSUE);
            ISSUE:   if (app_rdy && rem_q == LEN_W'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop is combinational so it lasts exactly the one IDLE cycle; gated so reset forces it low.
    assign fifo_rd_en = !rst && state == IDLE && !fifo_empty;
    assign app_en     = state == ISSUE;
    assign app_cmd    = app_en ? CMD_RD : 3'b000;
    assign app_addr   = addr_q;
    assign busy_o     = state != IDLE;
    assign done_o     = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            tag_pos_1st_o  <= '0;
            tag_pos_2nd_o  <= '0;
            tag_src_type_o <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                addr_q         <= ADDR_W'(c_addr);
                rem_q          <= c_len;
                tag_pos_1st_o  <= c_pos_1st;
                tag_pos_2nd_o  <= c_pos_2nd;
                tag_src_type_o <= c_src;
            end else if (app_en && app_rdy) begin
                addr_q <= addr_q + ADDR_W'(BURST_STEP);
                rem_q  <= rem_q - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mc_cmd_issuer.sv
// tb_mc_cmd_issuer: directed stimulus against a transaction-level burst/completion model.
module tb_mc_cmd_issuer;
    localparam int AW = 26;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    p1;
        logic [2:0]    p2;
        logic [1:0]    src;
        bit            last;
    } burst_t;

    logic          clk = 0, rst = 1, fifo_empty = 1, fifo_valid = 0, app_rdy = 1;
    logic [74:0]   fifo_dout = '0;
    logic          fifo_rd_en, app_en, busy_o, done_o, err_o;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [7:0]    tag_pos_1st_o;
    logic [2:0]    tag_pos_2nd_o;
    logic [1:0]    tag_src_type_o;

    logic [74:0]   fq[$];
    burst_t        exp_q[$];
    logic [AW-1:0] acc_log[$];
    int            pop_cyc[$], done_cyc[$];
    int            checks = 0, errors = 0, cyc = 0;
    int            n_done = 0, n_err = 0, n_pop = 0, n_en = 0, hold_cnt = 0;
    bit            pop_req = 0, done_exp = 0, err_exp = 0, in_cmd = 0, d_next, e_next, bad;
    logic [29:0]   m_len;
    logic [AW-1:0] m_addr;

    mc_cmd_issuer #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_dout      (fifo_dout),
        .fifo_valid     (fifo_valid),
        .app_en         (app_en),
        .app_cmd        (app_cmd),
        .app_addr       (app_addr),
        .app_rdy        (app_rdy),
        .tag_pos_1st_o  (tag_pos_1st_o),
        .tag_pos_2nd_o  (tag_pos_2nd_o),
        .tag_src_type_o (tag_src_type_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [74:0] mk(input bit v, input logic [1:0] src, input logic [7:0] p1,
                                       input logic [2:0] p2, input logic [29:0] a, input logic [29:0] n);
        return {n, a, src, p2, p1, 1'b0, v};
    endfunction

    // FIFO model: data and valid appear one cycle after the pop request.
    always @(posedge clk) begin
        #2;
        fifo_valid = pop_req && !rst && fq.size() != 0;
        if (fifo_valid) begin
            fifo_dout  = fq.pop_front();
            fifo_empty = fq.size() == 0;
        end
    end

    // Compare process: every burst the model predicts must appear in order, and each
    // command must complete (done or err) exactly one cycle after its deciding event.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pop_req = 0; done_exp = 0; err_exp = 0; in_cmd = 0;
        end else begin
            cyc++;
            d_next = 0; e_next = 0;
            check("busy_o", busy_o, in_cmd);
            check("done_o", done_o, done_exp);
            check("err_o", err_o, err_exp);
            check("app_en", app_en, exp_q.size() != 0);
            if (app_en) begin
                n_en++;
                if (app_addr == AW'('h0100008)) hold_cnt++;
                if (exp_q.size() != 0) begin
                    check("app_addr", app_addr, exp_q[0].addr);
                    check("app_cmd", app_cmd, 3'b001);
                    check("tag_pos_1st", tag_pos_1st_o, exp_q[0].p1);
                    check("tag_pos_2nd", tag_pos_2nd_o, exp_q[0].p2);
                    check("tag_src_type", tag_src_type_o, exp_q[0].src);
                    if (app_rdy) begin
                        acc_log.push_back(app_addr);
                        d_next = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done_o) begin n_done++; done_cyc.push_back(cyc); in_cmd = 0; end
            if (err_o) n_err++;
            if (fifo_rd_en) begin
                check("pop_while_busy", busy_o, 0);
                n_pop++;
                pop_cyc.push_back(cyc);
                in_cmd = 1;
            end
            if (fifo_valid) begin
                m_len  = fifo_dout[74:45];
                m_addr = fifo_dout[15 +: AW];
`ifdef MC_CMD_ISSUER_CHK_EN
                bad = !fifo_dout[0] || !(fifo_dout[14:13] == 2'b01 || fifo_dout[14:13] == 2'b10);
`else
                bad = 0;
`endif
                if (bad) begin e_next = 1; in_cmd = 0; end
                else if (m_len == 0) d_next = 1;
                else for (int i = 0; i < int'(m_len); i++)
                    exp_q.push_back('{AW'(m_addr + i * 8), fifo_dout[9:2], fifo_dout[12:10],
                                      fifo_dout[14:13], i == int'(m_len) - 1});
            end
            pop_req  = fifo_rd_en;
            done_exp = d_next;
            err_exp  = e_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input logic [74:0] w);
        fq.push_back(w);
        fifo_empty = 0;
    endtask

    task automatic clear();
        n_done = 0; n_err = 0; n_pop = 0; n_en = 0; hold_cnt = 0;
        acc_log.delete(); pop_cyc.delete(); done_cyc.delete();
    endtask

    task automatic wait_cmds(input int target, input string name);
        int k = 0;
        while (n_done + n_err < target && k < 300) begin tick(); k++; end
        if (n_done + n_err < target) begin
            checks++; errors++;
            $display("FAIL %s: timeout, completions %0d want %0d", name, n_done + n_err, target);
        end
        repeat (2) tick();
    endtask

    task automatic wait_addr(input logic [AW-1:0] a, input string name);
        int k = 0;
        while (!(app_en && app_addr == a) && k < 100) begin tick(); k++; end
        if (!(app_en && app_addr == a)) begin
            checks++; errors++;
            $display("FAIL %s: timeout, app_addr %0h want %0h", name, app_addr, a);
        end
    endtask

    initial begin
        push(mk(1, 2'b01, 8'hA5, 3'd5, 30'h0100000, 30'd4));
        repeat (2) tick();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy_o, 0);
        check("rst_app_en", app_en, 0);
        check("rst_app_addr", app_addr, 0);
        rst = 0;

        wait_cmds(1, "len4_rdy");
        check("len4_accepts", acc_log.size(), 4);
        check("len4_addr0", acc_log[0], 'h0100000);
        check("len4_addr1", acc_log[1], 'h0100008);
        check("len4_addr2", acc_log[2], 'h0100010);
        check("len4_addr3", acc_log[3], 'h0100018);
        check("len4_dones", n_done, 1);

        clear();
        push(mk(1, 2'b01, 8'hA5, 3'd5, 30'h0100000, 30'd4));
        wait_addr(AW'('h0100008), "stall_find");
        app_rdy = 0;
        repeat (3) tick();
        app_rdy = 1;
        wait_cmds(1, "stall");
        check("stall_hold_cycles", hold_cnt, 4);
        check("stall_accepts", acc_log.size(), 4);
        check("stall_dones", n_done, 1);

        clear();
        push(mk(1, 2'b10, 8'h3C, 3'd2, 30'h3FFFFF8, 30'd2));
        wait_cmds(1, "wrap");
        check("wrap_accepts", acc_log.size(), 2);
        check("wrap_addr0", acc_log[0], 'h3FFFFF8);
        check("wrap_addr1", acc_log[1], 'h0000000);

        clear();
        push(mk(1, 2'b10, 8'h11, 3'd1, 30'h0200000, 30'd3));
        push(mk(1, 2'b01, 8'h22, 3'd6, 30'h0300000, 30'd1));
        wait_cmds(2, "b2b");
        check("b2b_pops", n_pop, 2);
        check("b2b_dones", n_done, 2);
        check("b2b_pop_after_done", pop_cyc[1] > done_cyc[0], 1);
        check("b2b_last_addr", acc_log[3], 'h0300000);

        clear();
`ifdef MC_CMD_ISSUER_CHK_EN
        push(mk(1, 2'b11, 8'h01, 3'd0, 30'h0400000, 30'd2));
        wait_cmds(1, "bad_src");
        check("bad_src_err", n_err, 1);
        check("bad_src_done", n_done, 0);
        check("bad_src_en", n_en, 0);
`else
        push(mk(1, 2'b01, 8'h01, 3'd0, 30'h0400000, 30'd0));
        wait_cmds(1, "len0");
        check("len0_done", n_done, 1);
        check("len0_err", n_err, 0);
        check("len0_en", n_en, 0);
`endif

        clear();
        push(mk(1, 2'b01, 8'h77, 3'd3, 30'h0100000, 30'd8));
        wait_addr(AW'('h0100010), "rst_find");
        rst = 1;
        #1;
        check("mid_rst_app_en", app_en, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_addr", app_addr, 0);
        check("mid_rst_cmd", app_cmd, 0);
        check("mid_rst_tags", {tag_pos_1st_o, tag_pos_2nd_o, tag_src_type_o}, 0);
        repeat (2) tick();
        rst = 0;
        check("mid_rst_no_done", n_done, 0);
        clear();
        push(mk(1, 2'b10, 8'h5A, 3'd4, 30'h0500000, 30'd2));
        wait_cmds(1, "after_rst");
        check("after_rst_addr0", acc_log[0], 'h0500000);
        check("after_rst_addr1", acc_log[1], 'h0500008);
        check("after_rst_dones", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_cmd_issuer.md
MC_CMD_ISSUER -- requirements
Module: mc_cmd_issuer

Interface
REQ-001 Parameter ADDR_W, default 30, DDR application address width.
REQ-002 Parameter BURST_STEP, default 8, address increment per issued burst.
REQ-003 Parameter CMD_RD, default 3'b001, app_cmd opcode driven for every burst.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 fifo_empty  in  1  command FIFO empty.
REQ-007 fifo_rd_en  out  1  command FIFO pop request.
REQ-008 fifo_dout  in  75  command word: [0] valid, [1] reserved, [9:2] pos_1st, [12:10] pos_2nd, [14:13] src_type, [44:15] start address, [74:45] length in bursts.
REQ-009 fifo_valid  in  1  fifo_dout valid, one cycle after fifo_rd_en.
REQ-010 app_en  out  1  burst command strobe.
REQ-011 app_cmd  out  3  burst opcode.
REQ-012 app_addr  out  ADDR_W  burst address.
REQ-013 app_rdy  in  1  controller accepts command when app_en & app_rdy.
REQ-014 tag_pos_1st_o, tag_pos_2nd_o, tag_src_type_o  out  8/3/2  fields of command in progress.
REQ-015 busy_o  out  1  command in progress.
REQ-016 done_o  out  1  one-cycle pulse after last burst accepted.
REQ-017 err_o  out  1  one-cycle pulse on discarded command.

Function
REQ-018 FSM states IDLE, FETCH, ISSUE, DONE; reset state IDLE.
REQ-019 IDLE: if !fifo_empty, drive fifo_rd_en high for exactly one cycle, go FETCH; never pop outside IDLE.
REQ-020 FETCH: on fifo_valid, latch addr/length/tag fields; go ISSUE if length != 0, else DONE.
REQ-021 ISSUE: app_en high, app_addr = current address, app_cmd = CMD_RD; app_addr/app_cmd held stable while app_en & !app_rdy.
REQ-022 Each app_en & app_rdy cycle: address += BURST_STEP (modulo 2^ADDR_W, wrap silently), remaining -= 1.
REQ-023 Acceptance of final burst (remaining == 1) -> DONE same edge; app_en low next cycle.
REQ-024 DONE: done_o high one cycle, go IDLE; next pop no earlier than the cycle after DONE.
REQ-025 First app_en no later than 2 cycles after fifo_valid.
REQ-026 busy_o high in FETCH, ISSUE, DONE.
REQ-027 Length field is 30 bits; up to 2^30-1 bursts issued without counter overflow.
REQ-028 fifo_valid absent in FETCH: remain in FETCH, no timeout.

Reset
REQ-029 rst asserted: state IDLE, fifo_rd_en/app_en/done_o/err_o/busy_o 0, app_addr/app_cmd/tags 0, asynchronously.
REQ-030 rst mid-burst abandons the command; no done_o; FIFO contents untouched by this block.

Configuration
REQ-031 Macro MC_CMD_ISSUER_CHK_EN defined: in FETCH, command with bit[0]=0 or src_type not 2'b01/2'b10 is discarded, err_o pulses, no bursts, no done_o, return IDLE.
REQ-032 Macro undefined: no checks, err_o tied 0, zero length still goes to DONE with done_o.

Structure
REQ-033 Shared package ddr_define holds field bit positions, FSM state encoding, MC src_type codes.
REQ-034 One sub-module, mc_cmd_unpack, combinationally slices fifo_dout into fields.

Verification
REQ-035 Command addr 0x0100000, len 4, app_rdy always 1 -> app_addr 0x0100000,0x0100008,0x0100010,0x0100018 on consecutive cycles, one done_o.
REQ-036 Same command, app_rdy low 3 cycles at 2nd burst -> 0x0100008 held 4 cycles, still exactly 4 accepts.
REQ-037 Addr 0x3FFFFF8, len 2 -> bursts at 0x3FFFFF8 then 0x0000000.
REQ-038 Two back-to-back FIFO entries -> exactly two fifo_rd_en pulses, second after first done_o.
REQ-039 With MC_CMD_ISSUER_CHK_EN, src_type 2'b11 -> err_o pulse, no app_en; without it, len 0 -> done_o, no app_en.
REQ-040 rst asserted during 3rd of 8 bursts -> all outputs 0 immediately, IDLE, next command processed normally.
